// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined left shifter: default geometry,
// fill-mode constants and the payload carried from stage to stage.
package shifter_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_SHW   = 3;

   localparam logic MODE_LSL = 1'b0;
   localparam logic MODE_ROL = 1'b1;

   // shift_rem keeps the full amount; each stage clears the bit it consumed.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
      logic [DEF_SHW-1:0]   shift_rem;
      logic                 rot;
   } stage_payload_t;

endpackage

// File: rtl/lshift_pipe_stage.sv
// One registered mux layer: optionally shifts left by SHAMT with zero or
// rotate fill, then holds the result under a valid/ready handshake.
module lshift_pipe_stage
   import shifter_pkg::*;
#(
   parameter int SHAMT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_valid,
   output logic           o_ready,
   input  stage_payload_t i_payload,
   output logic           o_valid,
   input  logic           i_ready,
   output stage_payload_t o_payload
);

   localparam int SEL_BIT = $clog2(SHAMT);

   logic           w_sel;
   logic           w_rot;
   logic [DEF_WIDTH-1:0] w_mux;
   stage_payload_t w_next;
   logic           r_valid;
   stage_payload_t r_payload;

   assign w_sel = i_payload.shift_rem[SEL_BIT];
   assign w_rot = (i_payload.rot == MODE_ROL);

   for (genvar b = 0; b < DEF_WIDTH; b++) begin : g_bit
      if (b >= SHAMT) begin : g_shift
         assign w_mux[b] = w_sel ? i_payload.data[b-SHAMT] : i_payload.data[b];
      end else begin : g_fill
         // Vacated low bits take the bits leaving the MSB end when rotating.
         assign w_mux[b] = w_sel ? (w_rot & i_payload.data[DEF_WIDTH-SHAMT+b])
                                 : i_payload.data[b];
      end
   end

   always_comb begin
      w_next                   = i_payload;
      w_next.data              = w_mux;
      w_next.shift_rem[SEL_BIT] = 1'b0;
   end

   // An empty stage always accepts, so bubbles collapse.
   assign o_ready = !r_valid || i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_payload <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_payload <= w_next;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_payload = r_payload;

endmodule

// File: rtl/pipelined_lshift8.sv
// Pipelined 8-bit left shifter/rotator: layers shift by 4, 2, 1, each
// registered, with valid/ready on both sides and latency SHW cycles.
// Handshake: a word moves when valid && ready at a rising edge; stage k is
// ready when empty or when stage k+1 is ready (the last sees out_ready).
module pipelined_lshift8
   import shifter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW   = DEF_SHW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shift,
   input  logic             in_rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [SHW:0]   w_valid;
   logic [SHW:0]   w_ready;
   stage_payload_t w_pay [0:SHW];

   assign w_valid[0]        = in_valid;
   assign w_pay[0].data      = in_data;
   assign w_pay[0].shift_rem = in_shift;
   assign w_pay[0].rot       = in_rot;
   assign in_ready           = w_ready[0];
   assign w_ready[SHW]       = out_ready;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      lshift_pipe_stage #(
         .SHAMT (1 << (SHW - 1 - k))
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .i_valid   (w_valid[k]),
         .o_ready   (w_ready[k]),
         .i_payload (w_pay[k]),
         .o_valid   (w_valid[k+1]),
         .i_ready   (w_ready[k+1]),
         .o_payload (w_pay[k+1])
      );
   end

   // Output comes straight from the last stage register.
   assign out_valid = w_valid[SHW];
   assign out_data  = w_pay[SHW].data;

endmodule

// File: tb/tb_pipelined_lshift8.sv
// Self-checking bench for pipelined_lshift8: directed cases, streaming,
// backpressure, mid-stream reset and a randomised scoreboard run.
module tb_pipelined_lshift8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic [2:0] in_shift = 3'd0;
   logic       in_rot = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_out    = 0;
   bit chk_lat  = 1'b0;
   logic [7:0] cur_exp = 8'h00;
   logic [7:0] exp_q[$];
   int         cyc_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipelined_lshift8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shift  (in_shift),
      .in_rot    (in_rot),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic r);
      logic [15:0] shl;
      logic [7:0]  fill;
      shl  = {8'h00, d} << s;
      fill = (r && s != 3'd0) ? (d >> (4'd8 - {1'b0, s})) : 8'h00;
      return shl[7:0] | fill;
   endfunction

   // Observe transfers at the falling edge, then advance one cycle.
   task automatic step(output bit fired);
      int c0;
      fired = 1'b0;
      @(negedge clk);
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("spurious_out", {24'h0, out_data}, 32'hDEAD);
            end else begin
               check("data", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
               c0 = cyc_q.pop_front();
               if (chk_lat) check("latency", cyc - c0, 3);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            cyc_q.push_back(cyc);
            fired = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      bit f;
      int n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step(f);
         n++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic send_one(input logic [7:0] d, input logic [2:0] s, input logic r,
                           input logic [7:0] exp);
      bit f;
      int n;
      in_data = d; in_shift = s; in_rot = r; cur_exp = exp;
      in_valid = 1'b1; out_ready = 1'b1;
      n = 0; f = 1'b0;
      while (!f && n < 5) begin
         step(f);
         n++;
      end
      check("accept", f, 1);
      drain("drain_one", 10);
   endtask

   initial begin
      bit f;
      int idx, n, first_c, sent;
      logic [7:0] bp_exp [4];

      // Reset
      rst = 1'b1;
      step(f); step(f);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", {24'h0, out_data}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Directed single words with latency check
      chk_lat = 1'b1;
      send_one(8'hB5, 3'd3, 1'b0, 8'hA8);
      send_one(8'hB5, 3'd3, 1'b1, 8'hAD);
      send_one(8'h81, 3'd7, 1'b0, 8'h80);
      send_one(8'h81, 3'd7, 1'b1, 8'hC0);
      send_one(8'h5A, 3'd0, 1'b1, 8'h5A);
      send_one(8'h5A, 3'd0, 1'b0, 8'h5A);

      // Streaming 0x01 << 0..7 on consecutive cycles
      out_ready = 1'b1;
      in_data = 8'h01; in_rot = 1'b0;
      idx = 0; n = 0; first_c = -1;
      while (n_out < 6 + 8 && n < 30) begin
         if (idx < 8) begin
            in_valid = 1'b1; in_shift = idx[2:0]; cur_exp = 8'h01 << idx;
         end else begin
            in_valid = 1'b0;
         end
         step(f);
         if (f) idx++;
         if (n_out == 7 && first_c < 0) first_c = cyc;
         n++;
      end
      check("stream_count", n_out, 14);
      check("stream_span", cyc - first_c, 7);
      drain("drain_stream", 10);
      chk_lat = 1'b0;

      // Backpressure: 0x0F with shifts 1..4 while out_ready = 0
      bp_exp[0] = 8'h1E; bp_exp[1] = 8'h3C; bp_exp[2] = 8'h78; bp_exp[3] = 8'hF0;
      out_ready = 1'b0; in_data = 8'h0F; in_rot = 1'b0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (idx < 4); in_shift = 3'(idx + 1); cur_exp = bp_exp[idx & 3];
         step(f);
         if (f) idx++;
      end
      check("bp_accepts", idx, 3);
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold_data", {24'h0, out_data}, 32'h1E);
      @(posedge clk); #1;
      out_ready = 1'b1;
      n = 0;
      while ((idx < 4 || exp_q.size() != 0) && n < 20) begin
         in_valid = (idx < 4); in_shift = 3'(idx + 1); cur_exp = bp_exp[idx & 3];
         step(f);
         if (f) idx++;
         n++;
      end
      in_valid = 1'b0;
      check("bp_all_sent", idx, 4);
      check("bp_drained", exp_q.size(), 0);

      // Reset with two words in flight
      out_ready = 1'b1; in_data = 8'h33; in_shift = 3'd1; in_rot = 1'b1;
      cur_exp = 8'h66;
      in_valid = 1'b1;
      step(f); step(f);
      in_valid = 1'b0;
      rst = 1'b1;
      step(f);
      rst = 1'b0;
      exp_q.delete();
      cyc_q.delete();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("no_stale", out_valid, 0);
         @(posedge clk); #1;
      end

      // Random traffic against the model
      sent = 0; n = 0;
      in_valid = 1'b0;
      f = 1'b1;
      while (sent < 10000 && n < 60000) begin
         if (!in_valid || f) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom_range(0, 255));
            in_shift = 3'($urandom_range(0, 7));
            in_rot   = 1'($urandom_range(0, 1));
            cur_exp  = model(in_data, in_shift, in_rot);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         step(f);
         if (f) sent++;
         n++;
      end
      check("rand_sent", sent, 10000);
      drain("drain_rand", 20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
